// File: rtl/max_pooling2x2_nch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : max_pooling2x2_nch_pkg
// Purpose  : Shared definitions for the 2x2 stride-2 multi-channel max pooler:
//            fp32 element type, ordered-key mapping used for float compares,
//            lane slice helper and counter width helper.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package max_pooling2x2_nch_pkg;

   localparam int FP32_W    = 32;
   localparam int FP32_SIGN = FP32_W - 1;

   typedef logic [FP32_W-1:0] fp32_t;

   // Maps an IEEE-754 single to a key whose unsigned order equals numeric
   // order: positives get the MSB set, negatives are fully inverted so that
   // larger magnitudes sort lower. -0 becomes 0x7FFFFFFF and +0 becomes
   // 0x80000000, which is what makes +0 beat -0.
   function automatic fp32_t fp32_key(input fp32_t v);
      return v[FP32_SIGN] ? ~v : {1'b1, v[FP32_SIGN-1:0]};
   endfunction

   // Bit offset of a lane inside the packed channel bus.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

   // Counter width for a 0..n-1 counter; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : max_pooling2x2_nch_pkg
`default_nettype wire

// File: rtl/max_pooling2x2_nch_fp_max2.sv
`default_nettype none
// ============================================================================
// Module   : max_pooling2x2_nch_fp_max2
// Purpose  : Combinational two-input fp32 maximum for one channel lane.
//            Greater ordered key wins; on equal keys operand a wins.
// Ports    : a - first operand (wins ties)
//            b - second operand
//            y - maximum of a and b
// Revision : 1.0 - initial release
// ============================================================================
module max_pooling2x2_nch_fp_max2
   import max_pooling2x2_nch_pkg::*;
(
   input  logic [FP32_W-1:0] a,
   input  logic [FP32_W-1:0] b,
   output logic [FP32_W-1:0] y
);

   always_comb begin
      y = (fp32_key(b) > fp32_key(a)) ? b : a;
   end

endmodule : max_pooling2x2_nch_fp_max2
`default_nettype wire

// File: rtl/max_pooling2x2_nch.sv
`default_nettype none
// ============================================================================
// Module   : max_pooling2x2_nch
// Purpose  : Streaming 2x2 stride-2 max pooling over CHANNELS parallel fp32
//            lanes on a raster-order pixel stream. Odd trailing column/row
//            is consumed and ignored. One output per complete window, one
//            cycle after the window's bottom-right pixel.
// Ports    : clk     - clock
//            rst_n   - asynchronous active-low reset
//            i_clear - synchronous frame restart (beats i_valid)
//            i_valid - i_data carries one pixel this cycle
//            i_data  - packed lane pixels, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//            o_data  - packed pooled result, held while o_valid is low
//            o_valid - one-cycle result strobe
//            o_last  - with o_valid: final pooled pixel of the frame
// Revision : 1.0 - initial release
// ============================================================================
module max_pooling2x2_nch
   import max_pooling2x2_nch_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int IMAGE_WIDTH  = 4,
   parameter int IMAGE_HEIGHT = 4,
   parameter int CHANNELS     = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_clear,
   input  logic                         i_valid,
   input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
   output logic [CHANNELS*DATA_WIDTH-1:0] o_data,
   output logic                         o_valid,
   output logic                         o_last
);

   localparam int BUS_W  = CHANNELS * DATA_WIDTH;
   localparam int COL_W  = cnt_width(IMAGE_WIDTH);
   localparam int ROW_W  = cnt_width(IMAGE_HEIGHT);
   localparam int HALF_W = IMAGE_WIDTH / 2;
   localparam int IDX_W  = cnt_width(HALF_W);

   localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMAGE_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IMAGE_HEIGHT - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(2 * HALF_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(2 * (IMAGE_HEIGHT / 2) - 1);
   localparam logic             ODD_H    = 1'(IMAGE_HEIGHT % 2);

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [BUS_W-1:0] pair_reg;
   logic [BUS_W-1:0] row_buf [HALF_W];
   logic [BUS_W-1:0] buf_rd;
   logic [BUS_W-1:0] h_max;
   logic [BUS_W-1:0] v_max;
   logic [IDX_W-1:0] buf_idx;
   logic             accept;
   logic             in_rows;
   logic             buf_wr;
   logic             emit;

   // For odd widths the trailing even column never reaches an odd column,
   // so it can neither write the buffer nor emit. Odd heights need an
   // explicit gate on the trailing row.
   always_comb begin
      accept  = i_valid & ~i_clear;
      in_rows = ~ODD_H | (row != ROW_MAX);
      buf_idx = IDX_W'(col >> 1);
      buf_rd  = row_buf[buf_idx];
      buf_wr  = accept & col[0] & ~row[0] & in_rows;
      emit    = accept & col[0] &  row[0] & in_rows;
   end

   generate
      for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
         localparam int LSB = lane_lsb(k, DATA_WIDTH);

         max_pooling2x2_nch_fp_max2 u_hmax (
            .a (pair_reg[LSB +: DATA_WIDTH]),
            .b (i_data  [LSB +: DATA_WIDTH]),
            .y (h_max   [LSB +: DATA_WIDTH])
         );

         max_pooling2x2_nch_fp_max2 u_vmax (
            .a (buf_rd[LSB +: DATA_WIDTH]),
            .b (h_max [LSB +: DATA_WIDTH]),
            .y (v_max [LSB +: DATA_WIDTH])
         );
      end
   endgenerate

   // Data storage carries no reset: its contents are only ever read after
   // being written within the current frame.
   always_ff @(posedge clk) begin
      if (accept && !col[0]) begin
         pair_reg <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_wr) begin
         row_buf[buf_idx] <= h_max;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col     <= '0;
         row     <= '0;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_last  <= 1'b0;
      end else if (i_clear) begin
         col     <= '0;
         row     <= '0;
         o_valid <= 1'b0;
         o_last  <= 1'b0;
      end else begin
         o_valid <= emit;
         o_last  <= emit && (row == LAST_ROW) && (col == LAST_COL);
         if (emit) begin
            o_data <= v_max;
         end
         if (i_valid) begin
            if (col == COL_MAX) begin
               col <= '0;
               row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule : max_pooling2x2_nch
`default_nettype wire
